// File: rtl/divider_bank.sv
// Bank of independent programmable clock dividers: each channel emits a 50%-duty
// divided clock and a one-cycle tick, with glitch-free divisor reload on wrap.
module divider_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [CHANNELS-1:0]       enable_in,
  input  logic [CHANNELS*WIDTH-1:0] div_in,
  input  logic [CHANNELS-1:0]       load_in,
  input  logic                      sync_in,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick_out,
  output logic [CHANNELS-1:0]       pending_out
);

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0]    cnt_q  [CHANNELS];
  logic [WIDTH-1:0]    cnt_d  [CHANNELS];
  logic [WIDTH-1:0]    div_q  [CHANNELS];
  logic [WIDTH-1:0]    div_d  [CHANNELS];
  logic [WIDTH-1:0]    pdiv_q [CHANNELS];
  logic [WIDTH-1:0]    pdiv_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] clk_q, clk_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] at_wrap;

  always_comb begin
    at_wrap = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      at_wrap[c] = (div_q[c] != '0) && (cnt_q[c] == div_q[c] - ONE);
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    cnt_d  = cnt_q;
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sync_in) begin
        cnt_d[c] = '0;
        clk_d[c] = 1'b0;
        if (load_in[c]) begin
          div_d[c]  = div_in[c*WIDTH +: WIDTH];
          pend_d[c] = 1'b0;
        end else if (pend_q[c]) begin
          div_d[c]  = pdiv_q[c];
          pend_d[c] = 1'b0;
        end
      end else begin
        if (!enable_in[c]) begin
          if (pend_q[c]) cnt_d[c] = '0;
        end else if (div_q[c] == '0) begin
          cnt_d[c] = '0;
          clk_d[c] = 1'b0;
        end else if (at_wrap[c]) begin
          cnt_d[c]  = '0;
          clk_d[c]  = ~clk_q[c];
          tick_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + ONE;
        end
        // A frozen, stopped or wrapping channel is at a safe point to switch divisor.
        if (pend_q[c] && (!enable_in[c] || div_q[c] == '0 || at_wrap[c])) begin
          div_d[c]  = pdiv_q[c];
          pend_d[c] = 1'b0;
        end
        // A same-edge load lands in P after the old P was consumed above.
        if (load_in[c]) begin
          pdiv_d[c] = div_in[c*WIDTH +: WIDTH];
          pend_d[c] = 1'b1;
        end
      end
    end
  end

  // NOTE: the per-channel arrays are plain flops, so each entry is reset explicitly in a loop.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c]  <= '0;
        div_q[c]  <= RESET_DIV;
        pdiv_q[c] <= RESET_DIV;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make all state update together from pre-edge values.
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out     = clk_q;
  assign tick_out    = tick_q;
  assign pending_out = pend_q;

endmodule

// File: tb/tb_divider_bank.sv
// Self-checking bench for divider_bank: directed scenarios plus randomized traffic
// compared against an edge-count reference model of each channel.
module tb_divider_bank;

  localparam int CHANNELS    = 4;
  localparam int WIDTH       = 16;
  localparam int DEFAULT_DIV = 2;

  logic                      clk_in    = 1'b0;
  logic                      rst_n_in  = 1'b0;
  logic [CHANNELS-1:0]       enable_in = '0;
  logic [CHANNELS*WIDTH-1:0] div_in    = '0;
  logic [CHANNELS-1:0]       load_in   = '0;
  logic                      sync_in   = 1'b0;
  logic [CHANNELS-1:0]       clk_out, tick_out, pending_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: age = enabled edges since the current half-period began.
  int m_d    [CHANNELS];
  int m_p    [CHANNELS];
  int m_age  [CHANNELS];
  bit m_pend [CHANNELS];
  bit m_clk  [CHANNELS];
  bit m_tick [CHANNELS];

  int dv [CHANNELS] = '{1, 3, 7, 5000};
  int tcnt [CHANNELS];
  int q1[$], q2[$], q3[$];
  int e1[$], e2[$], e3[$];
  logic [CHANNELS-1:0] ev;
  bit hold_lvl;
  int frozen, gap;

  divider_bank #(
    .CHANNELS    (CHANNELS),
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .enable_in   (enable_in),
    .div_in      (div_in),
    .load_in     (load_in),
    .sync_in     (sync_in),
    .clk_out     (clk_out),
    .tick_out    (tick_out),
    .pending_out (pending_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_list(input string tag, input int got[$], input int exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) check(tag, got[i], exp[i]);
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_d[c] = DEFAULT_DIV; m_p[c] = DEFAULT_DIV; m_age[c] = 0;
      m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < CHANNELS; c++) begin
      int  sl;
      bit  apply;
      sl    = int'(div_in[c*WIDTH +: WIDTH]);
      apply = 0;
      m_tick[c] = 0;
      if (sync_in) begin
        m_age[c] = 0; m_clk[c] = 0;
        if (load_in[c]) begin m_d[c] = sl; m_pend[c] = 0; end
        else if (m_pend[c]) begin m_d[c] = m_p[c]; m_pend[c] = 0; end
      end else begin
        if (!enable_in[c]) begin
          if (m_pend[c]) begin apply = 1; m_age[c] = 0; end
        end else if (m_d[c] == 0) begin
          m_age[c] = 0; m_clk[c] = 0; apply = m_pend[c];
        end else begin
          m_age[c]++;
          if (m_age[c] % m_d[c] == 0) begin
            m_clk[c] = !m_clk[c]; m_tick[c] = 1; m_age[c] = 0; apply = m_pend[c];
          end
        end
        if (apply) begin m_d[c] = m_p[c]; m_pend[c] = 0; end
        if (load_in[c]) begin m_p[c] = sl; m_pend[c] = 1; end
      end
    end
  endfunction

  task automatic compare_outputs();
    logic [CHANNELS-1:0] ec, et, ep;
    for (int c = 0; c < CHANNELS; c++) begin
      ec[c] = m_clk[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
    end
    check("model_clk", clk_out, ec);
    check("model_tick", tick_out, et);
    check("model_pend", pending_out, ep);
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic set_div(input int c, input int v);
    div_in[c*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  initial begin
    model_reset();
    #2;
    compare_outputs();
    #10 rst_n_in = 1'b1;
    enable_in = '1;

    // Default divisor 2: toggles and ticks on every even edge.
    for (int n = 1; n <= 40; n++) begin
      step();
      check("t1_tick", tick_out, {CHANNELS{(n % 2) == 0}});
      check("t1_clk", clk_out, {CHANNELS{((n / 2) % 2) == 1}});
      check("t1_pend", pending_out, '0);
    end

    // Load 1, 3, 7, 5000 then sync; compare against the closed-form waveform.
    for (int c = 0; c < CHANNELS; c++) set_div(c, dv[c]);
    load_in = '1;
    step();
    load_in = '0;
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    for (int c = 0; c < CHANNELS; c++) tcnt[c] = 0;
    for (int n = 1; n <= 50000; n++) begin
      step();
      for (int c = 0; c < CHANNELS; c++) begin
        ev[c] = ((n / dv[c]) % 2) == 1;
        tcnt[c] += int'(tick_out[c]);
      end
      check("t2_clk", clk_out, ev);
    end
    for (int c = 0; c < CHANNELS; c++) check("t2_ticks", tcnt[c], 50000 / dv[c]);

    // Reloads: 3->5 at cnt 0 on ch1, load on wrap edge on ch2, double load on ch3.
    set_div(0, 2); set_div(1, 3); set_div(2, 4); set_div(3, 3);
    load_in = '1;
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      load_in = '0;
      if (n == 1) begin load_in[1] = 1'b1; set_div(1, 5); load_in[3] = 1'b1; set_div(3, 4); end
      if (n == 2) begin load_in[3] = 1'b1; set_div(3, 6); end
      if (n == 4) begin load_in[2] = 1'b1; set_div(2, 6); end
      step();
      if (n <= 3) check("t3_pend1", pending_out[1], n < 3);
      if (tick_out[1]) q1.push_back(n);
      if (tick_out[2]) q2.push_back(n);
      if (tick_out[3]) q3.push_back(n);
    end
    load_in = '0;
    e1 = '{3, 8, 13, 18};
    e2 = '{4, 8, 14, 20};
    e3 = '{3, 9, 15};
    check_list("t3_ch1_edges", q1, e1);
    check_list("t4_ch2_edges", q2, e2);
    check_list("t4_ch3_edges", q3, e3);

    // Divisor 0 stops channel 0 low.
    load_in[0] = 1'b1; set_div(0, 0);
    step();
    load_in = '0;
    repeat (4) step();
    for (int n = 0; n < 20; n++) begin
      step();
      check("t5_stop_clk", clk_out[0], 1'b0);
      check("t5_stop_tick", tick_out[0], 1'b0);
    end

    // Freeze channel 1 (D=5) for 10 cycles, then check it resumes mid-period.
    hold_lvl = m_clk[1];
    frozen   = m_age[1];
    enable_in[1] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      check("t5_hold_clk", clk_out[1], hold_lvl);
      check("t5_hold_tick", tick_out[1], 1'b0);
    end
    enable_in[1] = 1'b1;
    gap = 0;
    for (int g = 1; g <= 10 && gap == 0; g++) begin
      step();
      if (tick_out[1]) gap = g;
    end
    check("t5_resume_gap", gap, 5 - frozen);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CHANNELS; c++) enable_in[c] = ($urandom_range(0, 7) != 0);
      load_in = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if ($urandom_range(0, 15) == 0) begin
          load_in[c] = 1'b1;
          set_div(c, $urandom_range(0, 6));
        end
      end
      sync_in = ($urandom_range(0, 63) == 0);
      step();
    end
    sync_in = 1'b0;
    load_in = '0;

    // Asynchronous reset between edges with a load pending.
    enable_in = '1;
    set_div(2, 9);
    load_in[2] = 1'b1;
    step();
    load_in = '0;
    check("t6_pend_before", pending_out[2], 1'b1);
    #3 rst_n_in = 1'b0;
    #1;
    model_reset();
    check("t6_async_clk", clk_out, '0);
    check("t6_async_tick", tick_out, '0);
    check("t6_async_pend", pending_out, '0);
    #2 rst_n_in = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      check("t6_clk", clk_out, {CHANNELS{((n / 2) % 2) == 1}});
      check("t6_pend", pending_out, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
